// File: rtl/dmem_arbiter.sv
// Two-port (core C, debug D) arbiter onto a single-port byte-wide data memory.
// Splits byte/half/word requests into little-endian byte beats with round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {StIdle, StBeat, StDone, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [1:0]          r_cnt;
  logic                r_last_grant;
  logic                r_grant;
  logic                r_we;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rbuf;
  logic                r_c_err, r_d_err;
  logic [31:0]         r_c_rdata, r_d_rdata;

  logic                w_any;
  logic                w_sel;
  logic                w_sel_we;
  logic [1:0]          w_sel_size;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_sel_illegal;
  logic [1:0]          w_last_idx;
  logic [31:0]         w_rdata_fin;

  // On a tie the port that did not win last time is served; 0 = C, 1 = D.
  assign w_any       = c_req | d_req;
  assign w_sel       = (c_req & d_req) ? ~r_last_grant : d_req;
  assign w_sel_we    = w_sel ? d_we    : c_we;
  assign w_sel_size  = w_sel ? d_size  : c_size;
  assign w_sel_addr  = w_sel ? d_addr  : c_addr;
  assign w_sel_wdata = w_sel ? d_wdata : c_wdata;

  assign w_sel_illegal = (w_sel_size == 2'd3) ||
                         ((w_sel_size == 2'd1) && w_sel_addr[0]) ||
                         ((w_sel_size == 2'd2) && (w_sel_addr[1:0] != 2'b00));

  always_comb begin
    w_last_idx = 2'd0;
    unique case (r_size)
      2'd1:    w_last_idx = 2'd1;
      2'd2:    w_last_idx = 2'd3;
      default: w_last_idx = 2'd0;
    endcase
  end

  // The final byte arrives in DONE, one cycle after the last read beat.
  assign w_rdata_fin = r_we ? 32'h0 :
                       (r_rbuf | ({24'h0, mem_rdata} << {w_last_idx, 3'b000}));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_any) w_state_d = w_sel_illegal ? StResp : StBeat;
      StBeat: if (r_cnt == w_last_idx) w_state_d = StDone;
      StDone: w_state_d = StResp;
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= 2'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_rbuf       <= 32'h0;
      r_c_err      <= 1'b0;
      r_d_err      <= 1'b0;
      r_c_rdata    <= 32'h0;
      r_d_rdata    <= 32'h0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= w_sel_we;
            r_size       <= w_sel_size;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_cnt        <= 2'd0;
            r_rbuf       <= 32'h0;
            if (w_sel_illegal) begin
              if (w_sel) begin
                r_d_err   <= 1'b1;
                r_d_rdata <= 32'h0;
              end else begin
                r_c_err   <= 1'b1;
                r_c_rdata <= 32'h0;
              end
            end
          end
        end
        StBeat: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we && (r_cnt != 2'd0)) r_rbuf[{r_cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
        end
        StDone: begin
          if (r_grant) begin
            r_d_err   <= 1'b0;
            r_d_rdata <= w_rdata_fin;
          end else begin
            r_c_err   <= 1'b0;
            r_c_rdata <= w_rdata_fin;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces every output low at once so an aborted transfer issues no further beat.
  always_comb begin
    busy      = 1'b0;
    grant     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h0;
    c_ack     = 1'b0;
    d_ack     = 1'b0;
    c_err     = 1'b0;
    d_err     = 1'b0;
    c_rdata   = 32'h0;
    d_rdata   = 32'h0;
    if (!reset) begin
      busy    = (r_state != StIdle);
      grant   = busy & r_grant;
      c_err   = r_c_err;
      d_err   = r_d_err;
      c_rdata = r_c_rdata;
      d_rdata = r_d_rdata;
      if (r_state == StBeat) begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr + ADDR_W'(r_cnt);
        mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
      end
      if (r_state == StResp) begin
        c_ack = ~r_grant;
        d_ack = r_grant;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level model predicts grant order,
// beat schedule, ack cycles and read data from a shadow byte array.
module tb_dmem_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned MSIZE = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [1:0]    c_size = '0, d_size = '0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [31:0]   c_wdata = '0, d_wdata = '0;
  logic          c_ack, c_err, d_ack, d_err;
  logic [31:0]   c_rdata, d_rdata;
  logic          mem_en, mem_we, busy, grant;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h0;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment memory with one-cycle read latency.
  logic [7:0] mem [MSIZE];
  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic          vld;
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
  } beat_t;

  logic [7:0] ref_mem [MSIZE];
  int  ref_last;
  int  total = 0;
  int  bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t mk(input bit vld, input bit we, input int size, input int addr,
                              input logic [31:0] wdata);
    req_t r;
    r.vld = vld; r.we = we; r.size = size[1:0]; r.addr = addr[AW-1:0]; r.wdata = wdata;
    return r;
  endfunction

  function automatic int nbytes(input req_t r);
    return (r.size == 0) ? 1 : (r.size == 1) ? 2 : (r.size == 2) ? 4 : 0;
  endfunction

  function automatic bit illegal(input req_t r);
    int a = int'(r.addr);
    return (r.size == 3) || (r.size == 1 && a % 2 != 0) || (r.size == 2 && a % 4 != 0);
  endfunction

  // Model the effect of one granted transaction on the shadow memory.
  task automatic model_apply(input req_t r, output logic [31:0] rd);
    rd = 32'h0;
    if (!illegal(r)) begin
      for (int i = 0; i < nbytes(r); i++) begin
        int a = (int'(r.addr) + i) % MSIZE;
        if (r.we) ref_mem[a] = r.wdata[8*i +: 8];
        else      rd = rd + (32'(ref_mem[a]) << (8 * i));
      end
    end
  endtask

  task automatic run_pair(input req_t c, input req_t d);
    int          order [2];
    int          nord;
    int          s;
    int          ack_exp [2];
    logic [31:0] exp_rd [2];
    bit          exp_err [2];
    bit          exp_rd_chk [2];
    bit          done [2];
    beat_t       exp_b [$];
    beat_t       obs [$];
    req_t        rq [2];
    rq[0] = c; rq[1] = d;
    if (c.vld && d.vld) begin
      order[0] = (ref_last == 1) ? 0 : 1;
      order[1] = 1 - order[0];
      nord = 2;
    end else begin
      order[0] = c.vld ? 0 : 1;
      nord = 1;
    end
    ref_last = order[nord-1];

    @(negedge clock);
    c_req = c.vld; c_we = c.we; c_size = c.size; c_addr = c.addr; c_wdata = c.wdata;
    d_req = d.vld; d_we = d.we; d_size = d.size; d_addr = d.addr; d_wdata = d.wdata;
    s = cyc;
    for (int k = 0; k < nord; k++) begin
      int p = order[k];
      model_apply(rq[p], exp_rd[p]);
      exp_err[p]    = illegal(rq[p]);
      exp_rd_chk[p] = !exp_err[p] && !rq[p].we;
      if (!exp_err[p])
        for (int i = 0; i < nbytes(rq[p]); i++)
          exp_b.push_back('{s + 1 + i, AW'(int'(rq[p].addr) + i), rq[p].we,
                            rq[p].wdata[8*i +: 8]});
      ack_exp[p] = s + (exp_err[p] ? 1 : nbytes(rq[p]) + 2);
      s = ack_exp[p] + 1;
    end
    done[0] = !c.vld;
    done[1] = !d.vld;

    for (int k = 0; k < 40 && !(done[0] && done[1]); k++) begin
      @(negedge clock);
      if (mem_en) obs.push_back('{cyc, mem_addr, mem_we, mem_wdata});
      if (c_ack) begin
        if (done[0]) check_eq("c_ack_spurious", c_ack, 0);
        else begin
          check_eq("c_ack_cycle", cyc, ack_exp[0]);
          check_eq("c_err", c_err, exp_err[0]);
          check_eq("c_grant", grant, 0);
          if (exp_rd_chk[0]) check_eq("c_rdata", c_rdata, exp_rd[0]);
          c_req = 1'b0;
          done[0] = 1'b1;
        end
      end
      if (d_ack) begin
        if (done[1]) check_eq("d_ack_spurious", d_ack, 0);
        else begin
          check_eq("d_ack_cycle", cyc, ack_exp[1]);
          check_eq("d_err", d_err, exp_err[1]);
          check_eq("d_grant", grant, 1);
          if (exp_rd_chk[1]) check_eq("d_rdata", d_rdata, exp_rd[1]);
          d_req = 1'b0;
          done[1] = 1'b1;
        end
      end
    end
    check_eq("acks_seen", {done[0], done[1]}, 2'b11);
    check_eq("beat_count", obs.size(), exp_b.size());
    for (int i = 0; i < obs.size() && i < exp_b.size(); i++) begin
      check_eq("beat_cycle", obs[i].cyc, exp_b[i].cyc);
      check_eq("beat_addr", obs[i].addr, exp_b[i].addr);
      check_eq("beat_we", obs[i].we, exp_b[i].we);
      if (exp_b[i].we) check_eq("beat_wdata", obs[i].wdata, exp_b[i].wdata);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; c_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ref_last = 1;
    @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_acks", {c_ack, d_ack}, 0);
    check_eq("rst_errs", {c_err, d_err}, 0);
    check_eq("rst_c_rdata", c_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
  endtask

  task automatic mem_compare(input string tag);
    for (int i = 0; i < MSIZE; i++) check_eq(tag, mem[i], ref_mem[i]);
  endtask

  req_t none;
  int   t0;

  initial begin
    none = mk(0, 0, 0, 0, 0);
    for (int i = 0; i < MSIZE; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    do_reset();

    run_pair(mk(1, 1, 2, 'h08, 32'hDEADBEEF), none);
    run_pair(mk(1, 0, 2, 'h08, 0), none);
    check_eq("c_word_lit", c_rdata, 32'hDEADBEEF);
    run_pair(none, mk(1, 0, 0, 'h0A, 0));
    check_eq("d_byte_lit", d_rdata, 32'h000000AD);
    run_pair(none, mk(1, 0, 1, 'h0A, 0));
    check_eq("d_half_lit", d_rdata, 32'h0000DEAD);

    // Tie straight after reset: C first, then alternation.
    do_reset();
    run_pair(mk(1, 0, 0, 'h01, 0), mk(1, 0, 0, 'h02, 0));
    for (int i = 0; i < 3; i++) run_pair(mk(1, 0, 1, 'h04, 0), mk(1, 1, 0, 'h20 + i, i + 7));

    // Misaligned and illegal-size requests.
    run_pair(mk(1, 0, 2, 'h06, 0), none);
    run_pair(mk(1, 1, 1, 'h03, 32'h1234), none);
    run_pair(mk(1, 0, 3, 'h00, 0), none);
    mem_compare("mem_after_err");

    // Reset in the third beat of a word write to 0x10.
    @(negedge clock);
    c_req = 1'b1; c_we = 1'b1; c_size = 2'd2; c_addr = 6'h10; c_wdata = 32'h11223344;
    t0 = cyc;
    repeat (3) @(negedge clock);
    check_eq("abort_beat2_cycle", cyc, t0 + 3);
    check_eq("abort_beat2_addr", mem_addr, 6'h12);
    reset = 1'b1; c_req = 1'b0;
    @(negedge clock);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_mem_en", mem_en, 0);
    check_eq("abort_ack", c_ack, 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("abort_busy2", busy, 0);
    check_eq("abort_mem_en2", mem_en, 0);
    check_eq("abort_ack2", c_ack, 0);
    ref_mem[6'h10] = 8'h44;
    ref_mem[6'h11] = 8'h33;
    ref_last = 1;
    mem_compare("mem_after_abort");
    run_pair(mk(1, 0, 2, 'h10, 0), none);

    run_pair(none, mk(1, 1, 0, 'h3F, 32'h5A));
    run_pair(mk(1, 0, 0, 'h3F, 0), none);
    check_eq("c_byte_3f_lit", c_rdata, 32'h0000005A);
    run_pair(mk(1, 1, 2, 'h30, 32'hCAFEF00D), mk(1, 0, 2, 'h30, 0));

    for (int n = 0; n < 60; n++) begin
      req_t r [2];
      int   v = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        int sz = $urandom_range(0, 9);
        int a  = $urandom_range(0, MSIZE - 1);
        sz = (sz < 3) ? 0 : (sz < 6) ? 1 : (sz < 9) ? 2 : 3;
        if ($urandom_range(0, 4) != 0) begin
          if (sz == 1) a = a & ~1;
          if (sz == 2) a = a & ~3;
        end
        r[p] = mk(v[p], $urandom_range(0, 1), sz, a, $urandom);
      end
      run_pair(r[0], r[1]);
    end
    mem_compare("mem_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-wide data memory (one byte per access) between two requesters: the core MEM stage (port C) and the debug/loader port (port D).
- Splits each byte, halfword or word request into sequential byte beats in little-endian order.
- Assembles read data and returns a one-cycle acknowledge to the requester.
- Uses round-robin arbitration when both requesters are pending; the core holds its pipeline while c_req is high and c_ack is low.

Parameters:
- ADDR_W, 6, byte-address width; the memory holds 2^ADDR_W bytes.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  core request; held high until c_ack.
- c_we  in  1  1 = write, 0 = read.
- c_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- c_addr  in  ADDR_W  byte address.
- c_wdata  in  32  write data; low bytes are used for byte and half accesses.
- c_ack  out  1  one-cycle completion pulse.
- c_err  out  1  valid with c_ack; flags a misaligned or illegal-size request.
- c_rdata  out  32  read data, zero-extended, valid with c_ack.
- d_req, d_we, d_size, d_addr, d_wdata, d_ack, d_err, d_rdata: same as the c_ signals, for port D.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  read byte, valid the cycle after a read beat (1-cycle latency).
- busy  out  1  high whenever state != IDLE.
- grant  out  1  0 = C, 1 = D; valid while busy.

Behaviour:
- States: IDLE, BEAT, DONE, RESP.
- Reset (synchronous, takes priority in any state, including mid-transfer):
  - state = IDLE, beat counter = 0, last_grant = 1 (so C wins the first tie).
  - All outputs 0: mem_en, mem_we, acks, errs, rdata.
  - No further memory beats are issued for an aborted transfer.
- IDLE, arbitration:
  - Only C requesting: grant C. Only D requesting: grant D.
  - Both requesting: grant the port != last_grant.
  - On grant: latch we, size, addr, wdata; set last_grant.
  - Beat count n = 1, 2 or 4 for byte, half, word.
  - Alignment check: size 3, half with addr[0] = 1, or word with addr[1:0] != 0 makes the request illegal. An illegal request goes IDLE -> RESP with err = 1 and no memory access. A legal request goes IDLE -> BEAT with cnt = 0.
- BEAT:
  - mem_en = 1; mem_we = latched we; mem_addr = base + cnt (modulo 2^ADDR_W); mem_wdata = wdata byte cnt.
  - For reads with cnt > 0, capture mem_rdata into byte cnt-1 of the read buffer.
  - cnt increments each cycle; after beat n-1, go to DONE.
- DONE:
  - mem_en = 0.
  - For reads, capture mem_rdata into byte n-1; bytes above n-1 are 0.
  - Go to RESP.
- RESP:
  - ack of the granted port = 1 for exactly this cycle; rdata and err are valid in this cycle.
  - The other port's ack stays 0.
  - Go to IDLE.
- rdata/err hold value: they retain their value after RESP until the next RESP on the same port; they are not cleared.
- Latency (req first high in IDLE cycle t):
  - Byte: ack in cycle t+3.
  - Half: ack in cycle t+4.
  - Word: ack in cycle t+6.
  - Error: ack in cycle t+1.
  - A request arriving while busy waits; it is considered at the next IDLE.
- Back-to-back requests: the requester deasserts req in the cycle after ack; IDLE follows RESP, so re-arbitration happens one cycle after ack. A port's req seen in IDLE while its ack is high is ignored for that cycle.
- Requests are never preempted. Dropping req mid-transfer is a protocol violation; the transfer still completes and ack still pulses.
- Input changes after grant have no effect.

Test Plan:
- Reset, then C word write addr 0x08 data 0xDEADBEEF -> mem beats 0x08=EF, 0x09=BE, 0x0A=AD, 0x0B=DE on consecutive cycles; c_ack exactly once, 6 cycles after req; c_err = 0.
- C word read 0x08 after the above -> c_rdata = 0xDEADBEEF with c_ack. Then D byte read 0x0A -> d_rdata = 0x000000AD, ack at t+3. Then D half read 0x0A -> 0x0000DEAD, ack at t+4.
- C and D both request in the same IDLE cycle after reset -> C granted first (grant = 0), D next. Repeat with both requests held -> grants alternate D, C, D, with no starvation.
- C word read addr 0x06, half write addr 0x03, and size = 3 -> each gives c_err = 1 with c_ack at t+1; mem_en never asserted; memory contents unchanged.
- Reset asserted during BEAT of a word write to 0x10 (after 2 beats) -> next cycle busy = 0, mem_en = 0, no ack; bytes 0x10-0x11 written and 0x12-0x13 untouched. A new request afterwards completes normally.
- D byte write 0x3F data 0x5A, then C byte read 0x3F -> c_rdata = 0x0000005A. D requesting while C is busy -> d_ack only after c_ack, with no overlapping mem_en beats.
